stride_read_master: RTL and testbench

- Synthesizable AXI read initiator that drives the prefetcher's slave-side AR/R channels (s_ar_*, s_r_*) with a programmable strided burst-read stream.
- Issues req_num bursts at base_addr + k*stride, keeps up to max_outstanding bursts in flight and consumes every R beat.
- Checks ID, LAST and a data pattern on each beat and counts errors.
- Replaces hand-coded AR/R stimulus in prefetcher benches; also usable as an on-chip traffic source.

---
 rtl/stride_read_master.sv | 187 ++++++++++++++++++
 tb/tb_stride_read_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stride_read_master.sv
// Strided AXI burst-read initiator: issues req_num bursts at base + k*stride,
// keeps a bounded number in flight, and checks ID, LAST and address-pattern data per beat.
module stride_read_master #(
    parameter int ADDR_BITS            = 16,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int REQ_CNT_WIDTH        = 8,
    parameter int OUTST_WIDTH          = 3,
    parameter int ERR_CNT_WIDTH        = 8,
    parameter int DATA_WIDTH           = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       base_addr,
    input  logic [ADDR_BITS-1:0]       stride,
    input  logic [REQ_CNT_WIDTH-1:0]   req_num,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    input  logic [TID_WIDTH-1:0]       trans_id,
    input  logic [OUTST_WIDTH-1:0]     max_outstanding,
    input  logic                       check_en,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic                       m_r_last,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    output logic                       busy,
    output logic                       done,
    output logic [ERR_CNT_WIDTH-1:0]   err_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [REQ_CNT_WIDTH-1:0]   REQ_ZERO  = {REQ_CNT_WIDTH{1'b0}};
    localparam logic [REQ_CNT_WIDTH-1:0]   REQ_ONE   = REQ_CNT_WIDTH'(1);
    localparam logic [OUTST_WIDTH-1:0]     OUT_ZERO  = {OUTST_WIDTH{1'b0}};
    localparam logic [OUTST_WIDTH-1:0]     OUT_ONE   = OUTST_WIDTH'(1);
    localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ZERO = {BURST_LEN_WIDTH{1'b0}};
    localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ONE  = BURST_LEN_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0]   ERR_ZERO  = {ERR_CNT_WIDTH{1'b0}};
    localparam logic [ERR_CNT_WIDTH-1:0]   ERR_ONE   = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0]   ERR_MAX   = {ERR_CNT_WIDTH{1'b1}};

    // Expected beat data is the beat address zero-extended or truncated to the bus width.
    function automatic logic [DATA_WIDTH-1:0] addr_pattern(input logic [ADDR_BITS-1:0] addr);
        logic [DATA_WIDTH+ADDR_BITS-1:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, addr};
        return ext[DATA_WIDTH-1:0];
    endfunction

    state_t                     state_r;
    logic [ADDR_BITS-1:0]       stride_r, ar_addr_r, resp_addr_r;
    logic [REQ_CNT_WIDTH-1:0]   req_num_r, issued_r, completed_r;
    logic [BURST_LEN_WIDTH-1:0] len_r, beat_r;
    logic [TID_WIDTH-1:0]       id_r;
    logic [OUTST_WIDTH-1:0]     max_out_r, outstanding_r;
    logic                       check_r, ar_valid_r, r_ready_r, busy_r, done_r;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_r;

    logic                       ar_fire_s, r_fire_s, stray_s, beat_end_s, close_s, beat_err_s;
    logic [ADDR_BITS-1:0]       beat_addr_s;
    logic [REQ_CNT_WIDTH-1:0]   issued_n_s, completed_n_s;
    logic [OUTST_WIDTH-1:0]     out_n_s;

    assign m_ar_valid = ar_valid_r;
    assign m_ar_addr  = ar_addr_r;
    assign m_ar_len   = len_r;
    assign m_ar_id    = id_r;
    assign m_r_ready  = r_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err_cnt    = err_cnt_r;

    // Handshake decode, per-beat checks and next-cycle counter values.
    always_comb begin
        ar_fire_s   = ar_valid_r & m_ar_ready;
        r_fire_s    = r_ready_r & m_r_valid;
        stray_s     = r_fire_s & (outstanding_r == OUT_ZERO);
        beat_end_s  = (beat_r == len_r);
        close_s     = r_fire_s & ~stray_s & (m_r_last | beat_end_s);
        beat_addr_s = resp_addr_r + (ADDR_BITS'(beat_r) << LOG_BLOCK_DATA_BYTES);
        beat_err_s  = r_fire_s & (stray_s | (m_r_id != id_r) | (m_r_last != beat_end_s) |
                      (check_r & (m_r_data != addr_pattern(beat_addr_s))));
        issued_n_s    = ar_fire_s ? issued_r + REQ_ONE : issued_r;
        completed_n_s = close_s ? completed_r + REQ_ONE : completed_r;
        case ({ar_fire_s, close_s})
            2'b10:   out_n_s = outstanding_r + OUT_ONE;
            2'b01:   out_n_s = outstanding_r - OUT_ONE;
            default: out_n_s = outstanding_r;
        endcase
    end

    // Run-control FSM with registered AR/R handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r       <= IDLE;
            stride_r      <= {ADDR_BITS{1'b0}};
            ar_addr_r     <= {ADDR_BITS{1'b0}};
            resp_addr_r   <= {ADDR_BITS{1'b0}};
            req_num_r     <= REQ_ZERO;
            issued_r      <= REQ_ZERO;
            completed_r   <= REQ_ZERO;
            len_r         <= BEAT_ZERO;
            beat_r        <= BEAT_ZERO;
            id_r          <= {TID_WIDTH{1'b0}};
            max_out_r     <= OUT_ONE;
            outstanding_r <= OUT_ZERO;
            check_r       <= 1'b0;
            ar_valid_r    <= 1'b0;
            r_ready_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_cnt_r     <= ERR_ZERO;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        stride_r      <= stride;
                        ar_addr_r     <= base_addr;
                        resp_addr_r   <= base_addr;
                        req_num_r     <= req_num;
                        len_r         <= burst_len;
                        id_r          <= trans_id;
                        max_out_r     <= (max_outstanding == OUT_ZERO) ? OUT_ONE : max_outstanding;
                        check_r       <= check_en;
                        issued_r      <= REQ_ZERO;
                        completed_r   <= REQ_ZERO;
                        outstanding_r <= OUT_ZERO;
                        beat_r        <= BEAT_ZERO;
                        err_cnt_r     <= ERR_ZERO;
                        if (req_num != REQ_ZERO) begin
                            state_r    <= ISSUE;
                            ar_valid_r <= 1'b1;
                            r_ready_r  <= 1'b1;
                            busy_r     <= 1'b1;
                            done_r     <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    issued_r      <= issued_n_s;
                    completed_r   <= completed_n_s;
                    outstanding_r <= out_n_s;
                    if (ar_fire_s) begin
                        ar_addr_r <= ar_addr_r + stride_r;
                    end
                    // Stray beats (nothing outstanding) are flagged but never advance tracking.
                    if (close_s) begin
                        beat_r      <= BEAT_ZERO;
                        resp_addr_r <= resp_addr_r + stride_r;
                    end else if (r_fire_s && !stray_s) begin
                        beat_r <= beat_r + BEAT_ONE;
                    end
                    if (beat_err_s && (err_cnt_r != ERR_MAX)) begin
                        err_cnt_r <= err_cnt_r + ERR_ONE;
                    end
                    if (state_r == ISSUE) begin
                        if (issued_n_s == req_num_r) begin
                            state_r    <= DRAIN;
                            ar_valid_r <= 1'b0;
                        end else begin
                            ar_valid_r <= (out_n_s < max_out_r);
                        end
                    end else if ((out_n_s == OUT_ZERO) && (completed_n_s == req_num_r)) begin
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        r_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stride_read_master.sv
// Self-checking bench for stride_read_master: a responding memory model plus a
// scoreboard of expected AR addresses popped as the DUT issues requests.
module tb_stride_read_master;

    logic        clk = 1'b0;
    logic        resetN, start, check_en;
    logic [15:0] base_addr, stride;
    logic [7:0]  req_num, burst_len, trans_id;
    logic [2:0]  max_outstanding;
    logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id, m_r_data, m_r_id;
    logic        busy, done;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    stride_read_master #(
        .ADDR_BITS(16), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .LOG_BLOCK_DATA_BYTES(0),
        .REQ_CNT_WIDTH(8), .OUTST_WIDTH(3), .ERR_CNT_WIDTH(8), .DATA_WIDTH(8)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start), .base_addr(base_addr), .stride(stride),
        .req_num(req_num), .burst_len(burst_len), .trans_id(trans_id),
        .max_outstanding(max_outstanding), .check_en(check_en),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_id(m_r_id),
        .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] id;
        logic       fin;
    } beat_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    beat_t       beats[$];
    logic [15:0] exp_ar[$];
    int          cyc, ar_cnt, gen_idx, beats_seen, out_model, peak_out, last_r_cyc;
    int          stall_left, inj_id_idx, cur_num;
    bit          drop_last, hold_pend;
    logic [15:0] hold_addr, sl_addr, sl_tmp;
    logic [7:0]  cur_len, cur_id;
    beat_t       sl_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic run(input logic [15:0] base, input logic [15:0] strd, input logic [7:0] num,
                       input logic [7:0] len, input logic [2:0] mo, input logic [7:0] id,
                       input int stall, input int inj, input bit drop, input logic [7:0] exp_err);
        logic [15:0] a;
        int b0, t, mo_eff;
        step();
        a = base;
        for (int k = 0; k < int'(num); k++) begin
            exp_ar.push_back(a);
            a = a + strd;
        end
        cur_len = len; cur_id = id; cur_num = int'(num);
        inj_id_idx = inj; drop_last = drop; stall_left = stall;
        ar_cnt = 0; gen_idx = 0; peak_out = 0; b0 = beats_seen;
        mo_eff = (mo == 3'd0) ? 1 : int'(mo);
        base_addr = base; stride = strd; req_num = num; burst_len = len;
        trans_id = id; max_outstanding = mo; check_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        base_addr = 16'h5A5A; stride = 16'h1111; req_num = 8'd9; burst_len = 8'd7;
        trans_id = 8'd77; max_outstanding = 3'd7; check_en = 1'b0;
        if (num != 8'd0) begin
            chk("start_arvalid", 32'(m_ar_valid), 32'd1);
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_done_clr", 32'(done), 32'd0);
        end else begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_arvalid", 32'(m_ar_valid), 32'd0);
        end
        t = 0;
        while (!done && t < 2000) begin
            step();
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (num != 8'd0) chk("done_latency", 32'(cyc - last_r_cyc), 32'd1);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("beat_count", 32'(beats_seen - b0), 32'(int'(num) * (int'(len) + 1)));
        chk("ar_left", 32'(exp_ar.size()), 32'd0);
        chk("peak_outstanding_ok", 32'(peak_out <= mo_eff), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_rready", 32'(m_r_ready), 32'd0);
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; check_en = 1'b0;
        base_addr = 16'h0000; stride = 16'h0000; req_num = 8'd0; burst_len = 8'd0;
        trans_id = 8'd0; max_outstanding = 3'd0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = 8'd0; m_r_last = 1'b0; m_r_id = 8'd0;
        cyc = 0; ar_cnt = 0; gen_idx = 0; beats_seen = 0; out_model = 0; peak_out = 0;
        last_r_cyc = 0; stall_left = 0; inj_id_idx = -1; cur_num = 0; drop_last = 1'b0;
        hold_pend = 1'b0; hold_addr = 16'h0000; cur_len = 8'd0; cur_id = 8'd0;

        // Memory model: ready/valid driven on the falling edge, handshakes committed just after.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                m_ar_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (beats.size() > 0) begin
                    m_r_valid = 1'b1; m_r_data = beats[0].data;
                    m_r_last = beats[0].last; m_r_id = beats[0].id;
                end else begin
                    m_r_valid = 1'b0; m_r_data = 8'd0; m_r_last = 1'b0; m_r_id = 8'd0;
                end
                #1;
                if (!resetN) begin
                    beats.delete();
                    hold_pend = 1'b0;
                    out_model = 0;
                end else begin
                    if (hold_pend) begin
                        chk("ar_hold_valid", 32'(m_ar_valid), 32'd1);
                        chk("ar_hold_addr", 32'(m_ar_addr), 32'(hold_addr));
                    end
                    hold_pend = m_ar_valid && !m_ar_ready;
                    hold_addr = m_ar_addr;
                    if (m_ar_valid && m_ar_ready) begin
                        if (exp_ar.size() == 0) begin
                            chk("ar_unexpected", 32'(exp_ar.size()), 32'd1);
                        end else begin
                            sl_addr = exp_ar.pop_front();
                            chk("ar_addr", 32'(m_ar_addr), 32'(sl_addr));
                            chk("ar_len", 32'(m_ar_len), 32'(cur_len));
                            chk("ar_id", 32'(m_ar_id), 32'(cur_id));
                            for (int i = 0; i <= int'(cur_len); i++) begin
                                sl_tmp = sl_addr + i[15:0];
                                sl_beat.data = sl_tmp[7:0];
                                sl_beat.id = (gen_idx == inj_id_idx) ? 8'd6 : cur_id;
                                sl_beat.fin = (i == int'(cur_len));
                                sl_beat.last = sl_beat.fin && !(drop_last && ar_cnt == cur_num - 1);
                                beats.push_back(sl_beat);
                                gen_idx++;
                            end
                            ar_cnt++;
                            out_model++;
                        end
                    end
                    if (m_r_valid && m_r_ready) begin
                        sl_beat = beats.pop_front();
                        beats_seen++;
                        if (sl_beat.fin) begin
                            out_model--;
                            last_r_cyc = cyc;
                        end
                    end
                    if (out_model > peak_out) peak_out = out_model;
                end
            end
        join_none

        repeat (2) step();
        chk("rst_arvalid", 32'(m_ar_valid), 32'd0);
        chk("rst_rready", 32'(m_r_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        resetN = 1'b1;
        step();

        // base, stride, num, len, max_out, id, stall, inject-id beat, drop last, expected errors
        run(16'h0EEF, 16'h0000, 8'd1, 8'd0, 3'd1, 8'd5, 0, -1, 1'b0, 8'd0);
        run(16'h0100, 16'h0010, 8'd4, 8'd3, 3'd2, 8'd5, 0, -1, 1'b0, 8'd0);
        run(16'h0200, 16'h0040, 8'd2, 8'd1, 3'd1, 8'd5, 7, -1, 1'b0, 8'd0);
        run(16'h0300, 16'h0008, 8'd2, 8'd1, 3'd2, 8'd5, 0, 1, 1'b1, 8'd2);
        run(16'h0004, 16'hFFF8, 8'd2, 8'd1, 3'd1, 8'd5, 0, -1, 1'b0, 8'd0);
        run(16'h0400, 16'h0100, 8'd0, 8'd0, 3'd1, 8'd5, 0, -1, 1'b0, 8'd0);
        run(16'h0480, 16'h0020, 8'd3, 8'd2, 3'd0, 8'd9, 0, -1, 1'b0, 8'd0);

        // Reset in the middle of a stalled ISSUE phase.
        step();
        exp_ar.push_back(16'h0500);
        cur_len = 8'd3; cur_id = 8'd5; cur_num = 4; inj_id_idx = -1; drop_last = 1'b0;
        stall_left = 1000;
        base_addr = 16'h0500; stride = 16'h0010; req_num = 8'd4; burst_len = 8'd3;
        trans_id = 8'd5; max_outstanding = 3'd2; check_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("mid_arvalid", 32'(m_ar_valid), 32'd1);
        step();
        step();
        resetN = 1'b0;
        step();
        chk("midrst_arvalid", 32'(m_ar_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        resetN = 1'b1;
        stall_left = 0;
        exp_ar.delete();
        step();

        run(16'h0600, 16'h0004, 8'd2, 8'd0, 3'd2, 8'd3, 0, -1, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
